// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Round-robin arbiter sharing the single write port of a
//                2**ADDR_W x DATA_W register bank among NREQ writeback
//                sources. Grants combinationally, registers the winning
//                address/data/source and drives one-hot register enables.
//                Also keeps a saturating count of contended cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREQ   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ*DATA_W-1:0]     req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic [(2**ADDR_W)-1:0]     wr_en,
    output logic [DATA_W-1:0]          wr_data,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [1:0]                 wr_src,
    output logic                       wr_valid,
    output logic [15:0]                conflict_cnt
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    // Round-robin search start and registered output stage
    logic [1:0]         r_ptr;
    logic [c_DEPTH-1:0] r_wr_en;
    logic [DATA_W-1:0]  r_wr_data;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [1:0]         r_wr_src;
    logic               r_wr_valid;
    logic [15:0]        r_conflict_cnt;

    // Arbitration results
    logic [NREQ-1:0]    w_ready;
    logic               w_grant;
    logic [1:0]         w_grant_idx;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic [c_DEPTH-1:0] w_dec;
    logic [2:0]         w_nvalid;
    logic               w_conflict;

    // Round-robin pick: scan ptr..NREQ-1 first, then wrap to 0..ptr-1
    always_comb begin
        w_ready     = '0;
        w_grant     = 1'b0;
        w_grant_idx = '0;
        if (!rst && !stall) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_grant && req_valid[i] && (i >= int'(r_ptr))) begin
                    w_grant     = 1'b1;
                    w_grant_idx = 2'(i);
                    w_ready[i]  = 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!w_grant && req_valid[i] && (i < int'(r_ptr))) begin
                    w_grant     = 1'b1;
                    w_grant_idx = 2'(i);
                    w_ready[i]  = 1'b1;
                end
            end
        end
    end

    // Select the winner's address and data (w_ready is one-hot or zero)
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_ready[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Count valid requesters to detect contention
    always_comb begin
        w_nvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_nvalid = w_nvalid + 3'(req_valid[i]);
        end
        w_conflict = !stall && (w_nvalid >= 3'd2);
    end

    // Address decode; r0 is hardwired zero so its enable never fires
    assign w_dec[0] = 1'b0;
    for (genvar k = 1; k < c_DEPTH; k++) begin : g_dec
        assign w_dec[k] = (w_sel_addr == ADDR_W'(k));
    end

    // Pointer advances past the winner only when a grant is made
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            if (int'(w_grant_idx) == NREQ - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_grant_idx + 2'd1;
            end
        end
    end

    // Output stage: capture winner, pulse enables for one cycle per grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en    <= '0;
            r_wr_data  <= '0;
            r_wr_addr  <= '0;
            r_wr_src   <= '0;
            r_wr_valid <= 1'b0;
        end else if (w_grant) begin
            r_wr_en    <= w_dec;
            r_wr_data  <= w_sel_data;
            r_wr_addr  <= w_sel_addr;
            r_wr_src   <= w_grant_idx;
            r_wr_valid <= 1'b1;
        end else begin
            r_wr_en    <= '0;
            r_wr_valid <= 1'b0;
        end
    end

    // Saturating contention counter for the hazard logic
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    // A reset arriving while a write sits in the output stage cancels it,
    // so the bank registers never capture a write granted before reset.
    assign wr_en        = r_wr_en & {c_DEPTH{~rst}};
    assign wr_valid     = r_wr_valid & ~rst;
    assign wr_data      = r_wr_data;
    assign wr_addr      = r_wr_addr;
    assign wr_src       = r_wr_src;
    assign req_ready    = w_ready;
    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Directed self-checking bench for regfile_write_arbiter with
//                a small register-bank model fed by wr_en/wr_data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREQ   = 3;
    localparam int DEPTH  = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   stall;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic [DEPTH-1:0]       wr_en;
    logic [DATA_W-1:0]      wr_data;
    logic [ADDR_W-1:0]      wr_addr;
    logic [1:0]             wr_src;
    logic                   wr_valid;
    logic [15:0]            conflict_cnt;

    int tests = 0;
    int fails = 0;

    logic              bank_clr;
    logic [DATA_W-1:0] bank [DEPTH];

    regfile_write_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREQ(NREQ)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_en(wr_en), .wr_data(wr_data),
        .wr_addr(wr_addr), .wr_src(wr_src), .wr_valid(wr_valid),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Register bank model: each Register captures `in` when its regWrite is high
    always @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (bank_clr)      bank[k] <= '0;
            else if (wr_en[k]) bank[k] <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        logic [63:0] e;
        rst = 1'b1; stall = 1'b0; req_valid = 3'b111;
        req_addr = '0; req_data = '0; bank_clr = 1'b1;
        set_req(0, 5'd3, 32'h1111_1111);
        set_req(1, 5'd4, 32'h2222_2222);
        set_req(2, 5'd6, 32'h3333_3333);

        // Reset held 2 cycles with all requesters valid
        #1 chk("rst_ready", 64'(req_ready), 64'h0);
        tick; bank_clr = 1'b0;
        tick;
        chk("rst_wr_en",    64'(wr_en), 64'h0);
        chk("rst_wr_valid", 64'(wr_valid), 64'h0);
        chk("rst_wr_data",  64'(wr_data), 64'h0);
        chk("rst_wr_addr",  64'(wr_addr), 64'h0);
        chk("rst_wr_src",   64'(wr_src), 64'h0);
        chk("rst_cnt",      64'(conflict_cnt), 64'h0);

        // Single request to r7
        rst = 1'b0; req_valid = 3'b001;
        set_req(0, 5'd7, 32'hDEAD_BEEF);
        #1 chk("single_ready", 64'(req_ready), 64'h1);
        tick; req_valid = 3'b000;
        chk("single_wr_en",    64'(wr_en), 64'h80);
        chk("single_wr_data",  64'(wr_data), 64'hDEAD_BEEF);
        chk("single_wr_src",   64'(wr_src), 64'h0);
        chk("single_wr_addr",  64'(wr_addr), 64'h7);
        chk("single_wr_valid", 64'(wr_valid), 64'h1);
        tick;
        chk("single_bank7",  64'(bank[7]), 64'hDEAD_BEEF);
        chk("single_pulse",  64'(wr_en), 64'h0);
        chk("single_vdrop",  64'(wr_valid), 64'h0);

        // Requester 2 alone: pointer 1 -> grant 2 -> pointer wraps to 0
        req_valid = 3'b100;
        #1 chk("p2_ready", 64'(req_ready), 64'h4);
        tick;
        chk("p2_src", 64'(wr_src), 64'h2);

        // Round-robin fairness with all three valid for 6 cycles
        set_req(0, 5'd1, 32'hA000_0000);
        set_req(1, 5'd2, 32'hB000_0001);
        set_req(2, 5'd3, 32'hC000_0002);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            e = 64'd1 << (c % 3);
            #1 chk("rr_ready", 64'(req_ready), e);
            tick;
            chk("rr_src", 64'(wr_src), 64'(c % 3));
            chk("rr_en",  64'(wr_en), 64'd1 << ((c % 3) + 1));
        end
        req_valid = 3'b000;
        chk("rr_cnt", 64'(conflict_cnt), 64'd6);

        // Gap: grant 2, idle 3 cycles, then 011 -> requester 0 wins
        req_valid = 3'b100;
        #1 chk("gap_p2_ready", 64'(req_ready), 64'h4);
        tick; req_valid = 3'b000;
        tick; tick; tick;
        chk("gap_idle_valid", 64'(wr_valid), 64'h0);
        req_valid = 3'b011;
        #1 chk("gap_ready", 64'(req_ready), 64'h1);
        tick; req_valid = 3'b000;
        chk("gap_src", 64'(wr_src), 64'h0);
        chk("gap_cnt", 64'(conflict_cnt), 64'd7);

        // Write to r0: accepted but no enable
        set_req(1, 5'd0, 32'h0000_0055);
        req_valid = 3'b010;
        #1 chk("r0_ready", 64'(req_ready), 64'h2);
        tick; req_valid = 3'b000;
        chk("r0_valid", 64'(wr_valid), 64'h1);
        chk("r0_wr_en", 64'(wr_en), 64'h0);
        chk("r0_addr",  64'(wr_addr), 64'h0);
        chk("r0_data",  64'(wr_data), 64'h55);

        // Stall with all valid: no grant, no count, outputs hold
        stall = 1'b1; req_valid = 3'b111;
        #1 chk("stall_ready", 64'(req_ready), 64'h0);
        tick;
        chk("stall_wr_en", 64'(wr_en), 64'h0);
        chk("stall_valid", 64'(wr_valid), 64'h0);
        chk("stall_cnt",   64'(conflict_cnt), 64'd7);
        chk("stall_hold",  64'(wr_data), 64'h55);
        stall = 1'b0;
        #1 chk("stall_ptr", 64'(req_ready), 64'h4);
        tick; req_valid = 3'b000;
        chk("post_stall_src", 64'(wr_src), 64'h2);
        chk("post_stall_cnt", 64'(conflict_cnt), 64'd8);

        // Reset mid-operation: grant r5, then reset in the output cycle
        set_req(0, 5'd5, 32'h5555_5555);
        req_valid = 3'b001;
        #1 chk("mid_ready", 64'(req_ready), 64'h1);
        tick;
        chk("mid_pending", 64'(wr_en), 64'h20);
        rst = 1'b1; req_valid = 3'b111;
        #1 chk("mid_rst_ready", 64'(req_ready), 64'h0);
        chk("mid_rst_wr_en", 64'(wr_en), 64'h0);
        tick;
        chk("mid_wr_en",  64'(wr_en), 64'h0);
        chk("mid_valid",  64'(wr_valid), 64'h0);
        chk("mid_bank5",  64'(bank[5]), 64'h0);
        chk("mid_cnt",    64'(conflict_cnt), 64'h0);
        rst = 1'b0;
        #1 chk("mid_ptr", 64'(req_ready), 64'h1);

        // Saturation: 0x10005 contended cycles in total
        repeat (16'hFFFE) tick;
        chk("sat_fffe", 64'(conflict_cnt), 64'hFFFE);
        tick;
        chk("sat_ffff", 64'(conflict_cnt), 64'hFFFF);
        repeat (6) tick;
        chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
